// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the ID/EX pipeline stage.
//                - ALU control codes driven towards the EX-stage ALU
//                - Forwarding-select encoding (register file, EX/MEM, MEM/WB)
//                - Field values that make up a pipeline bubble
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // ALU operation codes
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_xor = 3'b100;
    localparam logic [2:0] c_alu_nor = 3'b101;
    localparam logic [2:0] c_alu_slt = 3'b110;

    // Where an ALU source operand is taken from
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Bubble contents: an invalid instruction with every side effect disabled
    localparam logic       c_bubble_valid     = 1'b0;
    localparam logic [2:0] c_bubble_alu_ctrl  = c_alu_add;
    localparam logic       c_bubble_reg_write = 1'b0;
    localparam logic       c_bubble_mem_read  = 1'b0;
    localparam logic       c_bubble_mem_write = 1'b0;
    localparam logic       c_bubble_alu_src   = 1'b0;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/fwd_unit.sv
// ============================================================================
//  Module      : fwd_unit
//  Description : Operand forwarding select for one ALU source register.
//                EX/MEM has priority over MEM/WB; register 0 is never
//                forwarded because its architectural value is always zero.
//  Ports       : i_src            - source register index of the operand
//                i_reg_data       - value captured from the register file
//                i_exmem_*        - EX/MEM writer (enable, index, result)
//                i_memwb_*        - MEM/WB writer (enable, index, result)
//                o_sel            - chosen source (fwd_sel_e)
//                o_data           - forwarded operand value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_unit
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic [RW-1:0]   i_src,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic            i_exmem_reg_write,
    input  logic [RW-1:0]   i_exmem_rd,
    input  logic [XLEN-1:0] i_exmem_result,
    input  logic            i_memwb_reg_write,
    input  logic [RW-1:0]   i_memwb_rd,
    input  logic [XLEN-1:0] i_memwb_result,
    output fwd_sel_e        o_sel,
    output logic [XLEN-1:0] o_data
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_reg_write & (i_exmem_rd != '0) & (i_exmem_rd == i_src);
    assign w_memwb_hit = i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_src);

    // The younger producer (EX/MEM) holds the newer value, so it wins.
    always_comb begin
        o_sel = FWD_REG;
        if (w_exmem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_memwb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        o_data = i_reg_data;
        case (o_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule : fwd_unit

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register feeding the EX-stage ALU.
//                Captures decoded fields each cycle, detects RAW hazards that
//                cannot be covered by forwarding (stall + bubble), honours
//                branch flushes and forwards EX/MEM and MEM/WB results into
//                the ALU operands.
//  Config      : ID_EX_FWD_EN - defined: forwarding muxes present, only a
//                load-use dependence stalls (one cycle).
//                Undefined: operands come from captured register data only;
//                any RAW against a writer in EX or EX/MEM stalls until the
//                producer reaches WB.
//  Ports       : clk, rst_n (async, active low)
//                flush_i        - kill the instruction entering EX
//                id_*           - decoded instruction fields from ID
//                exmem_*/memwb_*- forwarding sources
//                stall_o        - hold PC and IF/ID this cycle
//                ex_*           - EX-stage controls (registered)
//                ex_a/ex_b/ex_store_data - forwarded operands (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [2:0]      id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            exmem_reg_write,
    input  logic [RW-1:0]   exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RW-1:0]   memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [2:0]      ex_alu_ctrl,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data
);

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [RW-1:0]   r_rd;
    logic [XLEN-1:0] r_rs_data;
    logic [XLEN-1:0] r_rt_data;
    logic [XLEN-1:0] r_imm;
    logic            r_alu_src;
    logic [2:0]      r_alu_ctrl;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;

    logic            w_hazard;
    logic            w_bubble;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;

    // A flush kills the incoming instruction anyway, so holding the front
    // end for a hazard would only delay the redirect.
    assign w_bubble = flush_i | w_hazard;
    assign stall_o  = w_hazard & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= c_bubble_valid;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_src   <= c_bubble_alu_src;
            r_alu_ctrl  <= c_bubble_alu_ctrl;
            r_reg_write <= c_bubble_reg_write;
            r_mem_read  <= c_bubble_mem_read;
            r_mem_write <= c_bubble_mem_write;
        end else if (w_bubble) begin
            r_valid     <= c_bubble_valid;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_src   <= c_bubble_alu_src;
            r_alu_ctrl  <= c_bubble_alu_ctrl;
            r_reg_write <= c_bubble_reg_write;
            r_mem_read  <= c_bubble_mem_read;
            r_mem_write <= c_bubble_mem_write;
        end else begin
            r_valid     <= id_valid;
            r_rd        <= id_rd;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_alu_ctrl  <= id_alu_ctrl;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
        end
    end

`ifdef ID_EX_FWD_EN
    // ------------------------------------------------------------------
    // Forwarding build: source indices travel with the instruction so the
    // operand muxes can compare them against the downstream writers.
    // ------------------------------------------------------------------
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    fwd_sel_e      w_rs_sel;
    fwd_sel_e      w_rt_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs <= '0;
            r_rt <= '0;
        end else if (w_bubble) begin
            r_rs <= '0;
            r_rt <= '0;
        end else begin
            r_rs <= id_rs;
            r_rt <= id_rt;
        end
    end

    // Only a load in EX cannot be forwarded in time: its data exists after
    // MEM, one cycle too late for the dependent instruction.
    assign w_hazard = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs) | (r_rd == id_rt));

    fwd_unit #(
        .XLEN (XLEN),
        .RW   (RW)
    ) u_fwd_rs (
        .i_src             (r_rs),
        .i_reg_data        (r_rs_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_sel             (w_rs_sel),
        .o_data            (w_rs_val)
    );

    fwd_unit #(
        .XLEN (XLEN),
        .RW   (RW)
    ) u_fwd_rt (
        .i_src             (r_rt),
        .i_reg_data        (r_rt_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_sel             (w_rt_sel),
        .o_data            (w_rt_val)
    );

    // The select codes are kept for observability only.
    logic w_unused_sel;
    assign w_unused_sel = ^{w_rs_sel, w_rt_sel};
`else
    // ------------------------------------------------------------------
    // Non-forwarding build: any in-flight producer of a source register
    // holds the instruction in ID until the producer reaches WB, where the
    // register file write-through supplies the value.
    // ------------------------------------------------------------------
    logic w_ex_raw;
    logic w_exmem_raw;

    assign w_ex_raw    = r_valid & (r_reg_write | r_mem_read) & (r_rd != '0) &
                         ((r_rd == id_rs) | (r_rd == id_rt));
    assign w_exmem_raw = exmem_reg_write & (exmem_rd != '0) &
                         ((exmem_rd == id_rs) | (exmem_rd == id_rt));
    assign w_hazard    = id_valid & (w_ex_raw | w_exmem_raw);

    assign w_rs_val = r_rs_data;
    assign w_rt_val = r_rt_data;

    // Forwarding sources have no consumer in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_valid      = r_valid;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;

    assign ex_a          = w_rs_val;
    assign ex_b          = r_alu_src ? r_imm : w_rt_val;
    assign ex_store_data = w_rt_val;

endmodule : id_ex_stage

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. A behavioural model
//                tracks the instruction held in EX and predicts every output;
//                directed sequences cover reset, capture, forwarding
//                priority, immediates, load-use, flush and reset-mid-stall,
//                followed by randomized traffic.
//  Config      : ID_EX_FWD_EN selects the forwarding expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush_i = 1'b0;
    logic            id_valid = 1'b0;
    logic [RW-1:0]   id_rs = '0, id_rt = '0, id_rd = '0;
    logic [XLEN-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic            id_alu_src = 1'b0;
    logic [2:0]      id_alu_ctrl = '0;
    logic            id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic            exmem_reg_write = 1'b0;
    logic [RW-1:0]   exmem_rd = '0;
    logic [XLEN-1:0] exmem_result = '0;
    logic            memwb_reg_write = 1'b0;
    logic [RW-1:0]   memwb_rd = '0;
    logic [XLEN-1:0] memwb_result = '0;
    logic            stall_o;
    logic            ex_valid;
    logic [2:0]      ex_alu_ctrl;
    logic [RW-1:0]   ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;
    logic [XLEN-1:0] ex_a, ex_b, ex_store_data;

    id_ex_stage #(.XLEN(XLEN), .RW(RW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_alu_src      (id_alu_src),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .stall_o         (stall_o),
        .ex_valid        (ex_valid),
        .ex_alu_ctrl     (ex_alu_ctrl),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_store_data   (ex_store_data)
    );

    always #5 clk = ~clk;

`ifdef ID_EX_FWD_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction currently sitting in EX, as the model sees it
    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
        bit        alu_src;
        bit [2:0]  ctrl;
        bit        rw, mr, mw;
    } ex_t;

    ex_t m;

    function automatic ex_t bubble();
        ex_t b;
        b = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, rsd: 32'd0, rtd: 32'd0,
              imm: 32'd0, alu_src: 1'b0, ctrl: 3'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Newest value of register src as seen by the instruction in EX
    function automatic bit [31:0] operand(bit [4:0] src, bit [31:0] captured);
        if (c_fwd) begin
            if (exmem_reg_write && exmem_rd != 0 && exmem_rd == src) return exmem_result;
            if (memwb_reg_write && memwb_rd != 0 && memwb_rd == src) return memwb_result;
        end
        return captured;
    endfunction

    function automatic bit reads(bit [4:0] r);
        return id_valid && r != 0 && (id_rs == r || id_rt == r);
    endfunction

    // Must the ID instruction wait this cycle?
    function automatic bit must_wait();
        if (c_fwd)
            return m.valid && m.mr && reads(m.rd);
        return (m.valid && (m.rw || m.mr) && reads(m.rd)) ||
               (exmem_reg_write && reads(exmem_rd));
    endfunction

    task automatic check_outputs();
        check("stall",     {31'd0, stall_o},      {31'd0, must_wait() && !flush_i});
        check("valid",     {31'd0, ex_valid},     {31'd0, m.valid});
        check("alu_ctrl",  {29'd0, ex_alu_ctrl},  {29'd0, m.ctrl});
        check("rd",        {27'd0, ex_rd},        {27'd0, m.rd});
        check("reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
        check("mem_read",  {31'd0, ex_mem_read},  {31'd0, m.mr});
        check("mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
        check("a",         ex_a,                  operand(m.rs, m.rsd));
        check("b",         ex_b,                  m.alu_src ? m.imm : operand(m.rt, m.rtd));
        check("store",     ex_store_data,         operand(m.rt, m.rtd));
    endtask

    // Called at a negedge with inputs driven: checks, clocks once, returns at
    // the next negedge.
    task automatic step();
        ex_t nxt;
        #1;
        check_outputs();
        if (flush_i || must_wait())
            nxt = bubble();
        else
            nxt = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, rsd: id_rs_data,
                    rtd: id_rt_data, imm: id_imm, alu_src: id_alu_src, ctrl: id_alu_ctrl,
                    rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
        @(posedge clk);
        m = nxt;
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                          input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                          input bit asrc, input bit [2:0] ctrl, input bit rw, input bit mr,
                          input bit mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = asrc;
        id_alu_ctrl = ctrl; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic randomize_inputs();
        set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
               3'($urandom_range(0, 6)), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
        flush_i         = $urandom_range(0, 9) == 0;
        exmem_reg_write = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 7));
        exmem_result    = $urandom;
        memwb_reg_write = 1'($urandom);
        memwb_rd        = 5'($urandom_range(0, 7));
        memwb_result    = $urandom;
    endtask

    initial begin
        m = bubble();

        // Reset state
        #1;
        check_outputs();
        check("reset_a", ex_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain capture: add rs=1(5), rt=2(7)
        set_id(1, 1, 2, 6, 32'd5, 32'd7, 32'd0, 0, 3'b000, 1, 0, 0);
        step();
        #1;
        check("plain_a", ex_a, 32'd5);
        check("plain_b", ex_b, 32'd7);
        check("plain_ctrl", {29'd0, ex_alu_ctrl}, 32'd0);

        // Forwarding priority on rs=3
        set_id(1, 3, 0, 0, 32'h33, 32'd0, 32'd0, 0, 3'b001, 0, 0, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1 check("fwd_exmem", ex_a, c_fwd ? 32'h11 : 32'h33);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", ex_a, c_fwd ? 32'h22 : 32'h33);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_r0", ex_a, 32'h33);
        step();
        clear_fwd();

        // Immediate operand with rt forwarded from MEM/WB
        set_id(1, 0, 5, 1, 32'd0, 32'h55, 32'hFFFF_FFF0, 1, 3'b000, 1, 0, 1);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'd9;
        #1;
        check("imm_b", ex_b, 32'hFFFF_FFF0);
        check("imm_store", ex_store_data, c_fwd ? 32'd9 : 32'h55);
        step();
        clear_fwd();

        // Load-use: lw r4 in EX, consumer in ID
        set_id(1, 0, 0, 4, 0, 0, 32'h40, 1, 3'b000, 1, 1, 0);
        step();
        set_id(1, 4, 0, 7, 32'h44, 0, 0, 0, 3'b011, 1, 0, 0);
        #1 check("lu_stall", {31'd0, stall_o}, 32'd1);
        step();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h40;
        #1 check("lu_stall2", {31'd0, stall_o}, c_fwd ? 32'd0 : 32'd1);
        step();
        exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hABCD_1234;
        if (c_fwd) begin
            #1 check("lu_issue_a", ex_a, 32'hABCD_1234);
        end else begin
            #1 check("lu_nofwd_release", {31'd0, stall_o}, 32'd0);
        end
        step();
        clear_fwd();
        step();

        // Flush and hazard together: flush wins, no stall
        set_id(1, 0, 0, 4, 0, 0, 0, 1, 3'b000, 1, 1, 0);
        step();
        set_id(1, 4, 4, 2, 32'h1, 32'h2, 0, 0, 3'b010, 1, 0, 0);
        flush_i = 1;
        #1 check("flush_stall", {31'd0, stall_o}, 32'd0);
        step();
        flush_i = 0;
        check("flush_bubble", {31'd0, ex_valid}, 32'd0);

        // Reset in the middle of a stall
        set_id(1, 0, 0, 4, 0, 0, 0, 1, 3'b000, 1, 1, 0);
        step();
        set_id(1, 4, 0, 3, 32'h44, 32'd0, 0, 0, 3'b100, 1, 0, 0);
        #1 check("rst_pre_stall", {31'd0, stall_o}, 32'd1);
        rst_n = 1'b0;
        m = bubble();
        #1;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        #1;
        check("rst_first_valid", {31'd0, ex_valid}, 32'd1);
        check("rst_first_a", ex_a, 32'h44);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_ex_stage

`default_nettype wire
